// File: rtl/ddr3_traffic_gen.sv
// Write/read-back traffic generator for one MCB user port: writes NUM_BURSTS
// address-tagged bursts, reads each one back and counts data mismatches.
module ddr3_traffic_gen #(
  parameter logic [29:0] BASE_ADDR  = 30'h0000000,
  parameter int          BURST_LEN  = 4,
  parameter int          NUM_BURSTS = 16
) (
  input  logic         c1_clk0,
  input  logic         c1_rst0,
  input  logic         calib_done,
  input  logic         start,
  output logic         p0_cmd_en,
  output logic [2:0]   p0_cmd_instr,
  output logic [5:0]   p0_cmd_bl,
  output logic [29:0]  p0_cmd_byte_addr,
  input  logic         p0_cmd_full,
  output logic         p0_wr_en,
  output logic [15:0]  p0_wr_mask,
  output logic [127:0] p0_wr_data,
  input  logic         p0_wr_full,
  input  logic [6:0]   p0_wr_count,
  output logic         p0_rd_en,
  input  logic [127:0] p0_rd_data,
  input  logic         p0_rd_empty,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [15:0]  err_cnt
);

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_CMD, WAIT_WR, RD_CMD, RD_DATA, DONE
  } state_t;

  localparam logic [5:0]  LAST_K      = 6'(BURST_LEN - 1);
  localparam logic [9:0]  LAST_B      = 10'(NUM_BURSTS - 1);
  localparam logic [29:0] BURST_BYTES = 30'(BURST_LEN * 16);

  state_t        r_state;
  state_t        w_next;
  logic [9:0]    r_b;
  logic [5:0]    r_k;
  logic [29:0]   r_addr;
  logic          r_done;
  logic          r_error;
  logic [15:0]   r_err_cnt;

  logic          w_busy;
  logic          w_calib_lost;
  logic          w_go;
  logic          w_last_k;
  logic [29:0]   w_word_addr;
  logic [31:0]   w_word_d;
  logic [127:0]  w_word;

  assign w_busy       = (r_state != IDLE) && (r_state != DONE);
  assign w_calib_lost = w_busy && !calib_done;
  assign w_go         = (r_state == IDLE) && start && calib_done;
  assign w_last_k     = (r_k == LAST_K);

  // Each word carries its own byte address plus the low burst-index bits,
  // so a misplaced or stale word is caught on read-back.
  assign w_word_addr = r_addr + {20'd0, r_k, 4'd0};
  assign w_word_d    = {r_b[1:0], w_word_addr};
  assign w_word      = {4{w_word_d}};

  assign busy       = w_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign err_cnt    = r_err_cnt;
  assign p0_wr_mask = 16'h0000;

  always_ff @(posedge c1_clk0) begin
    if (c1_rst0) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // NOTE: every output and w_next gets a default before the case, so no
  // path through this block leaves a signal unassigned and no latch appears.
  always_comb begin
    w_next           = r_state;
    p0_cmd_en        = 1'b0;
    p0_cmd_instr     = 3'b000;
    p0_cmd_bl        = 6'd0;
    p0_cmd_byte_addr = 30'd0;
    p0_wr_en         = 1'b0;
    p0_wr_data       = 128'd0;
    p0_rd_en         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && calib_done) w_next = WR_DATA;
      end
      WR_DATA: begin
        p0_wr_data = w_word;
        if (!p0_wr_full) begin
          p0_wr_en = 1'b1;
          if (w_last_k) w_next = WR_CMD;
        end
      end
      WR_CMD: begin
        p0_cmd_bl        = LAST_K;
        p0_cmd_byte_addr = r_addr;
        if (!p0_cmd_full) begin
          p0_cmd_en = 1'b1;
          w_next    = WAIT_WR;
        end
      end
      WAIT_WR: begin
        if (p0_wr_count == 7'd0) w_next = RD_CMD;
      end
      RD_CMD: begin
        p0_cmd_instr     = 3'b001;
        p0_cmd_bl        = LAST_K;
        p0_cmd_byte_addr = r_addr;
        if (!p0_cmd_full) begin
          p0_cmd_en = 1'b1;
          w_next    = RD_DATA;
        end
      end
      RD_DATA: begin
        if (!p0_rd_empty) begin
          p0_rd_en = 1'b1;
          if (w_last_k) w_next = (r_b == LAST_B) ? DONE : WR_DATA;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_calib_lost) w_next = IDLE;
    // An aborting cycle must not touch the MCB, even before the edge lands.
    if (w_calib_lost || c1_rst0) begin
      p0_cmd_en = 1'b0;
      p0_wr_en  = 1'b0;
      p0_rd_en  = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge c1_clk0) begin
    if (c1_rst0) begin
      r_b       <= 10'd0;
      r_k       <= 6'd0;
      r_addr    <= 30'd0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_err_cnt <= 16'd0;
    end else if (w_calib_lost) begin
      r_error <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      if (w_go) begin
        r_b       <= 10'd0;
        r_k       <= 6'd0;
        r_addr    <= BASE_ADDR;
        r_done    <= 1'b0;
        r_error   <= 1'b0;
        r_err_cnt <= 16'd0;
      end
      if (p0_wr_en) r_k <= w_last_k ? 6'd0 : r_k + 6'd1;
      if (p0_cmd_en && (r_state == RD_CMD)) r_k <= 6'd0;
      if (p0_rd_en) begin
        if (p0_rd_data != w_word) begin
          r_error <= 1'b1;
          if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        end
        if (w_last_k) begin
          r_k <= 6'd0;
          if (r_b != LAST_B) begin
            r_b    <= r_b + 10'd1;
            r_addr <= r_addr + BURST_BYTES;
          end else begin
            r_done <= 1'b1;
          end
        end else begin
          r_k <= r_k + 6'd1;
        end
      end
    end
  end

endmodule
